// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary weight path: weight codes, checksum seed,
// loader state encoding and the frame-size formula used by loader and multiplier.
package tt_ternary_pkg;

    localparam logic [1:0] TW_ZERO    = 2'b00;
    localparam logic [1:0] TW_POS     = 2'b01;
    localparam logic [1:0] TW_NEG     = 2'b11;

    localparam logic [7:0] CKSUM_SEED = 8'hA5;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_DATA   = 2'd1,
        LD_CKSUM  = 2'd2,
        LD_COMMIT = 2'd3
    } ld_state_e;

    // Bytes needed to carry a 2-bit weight for every row/column pair.
    function automatic int unsigned tw_nbytes(input int unsigned in_len,
                                              input int unsigned out_len);
        return (2 * in_len * out_len) / 8;
    endfunction

endpackage

// File: rtl/ternary_code_canon.sv
// Maps a raw 2-bit weight code onto the canonical set {00, 01, 11}.
module ternary_code_canon
    import tt_ternary_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [1:0] code_o
);

    // The multiplier keys negation off bit 1, so 10 is folded into -1.
    always_comb begin
        code_o = code_i;
        if (code_i == 2'b10) begin
            code_o = TW_NEG;
        end
    end

endmodule

// File: rtl/ternary_weight_loader.sv
// Byte-serial loader for the ternary weight matrix: fills a shadow copy, verifies
// a trailing checksum and swaps the canonicalised shadow into W in one cycle.
module ternary_weight_loader
    import tt_ternary_pkg::*;
#(
    parameter int unsigned InLen  = 16,
    parameter int unsigned OutLen = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid,
    output logic                       byte_ready,
    input  logic                       commit_hold,
    output logic [2*InLen*OutLen-1:0]  W,
    output logic                       w_valid,
    output logic                       w_updated,
    output logic                       load_busy,
    output logic                       load_err
);

    localparam int unsigned NBytes = tw_nbytes(InLen, OutLen);
    localparam int unsigned WBits  = 2 * InLen * OutLen;
    localparam int unsigned NCodes = InLen * OutLen;
    localparam int unsigned CntW   = $clog2(NBytes);

    ld_state_e         state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        cksum_q, cksum_d;
    logic [WBits-1:0]  shadow_q, shadow_d;
    logic [WBits-1:0]  w_q, w_d;
    logic              w_valid_q, w_valid_d;
    logic              w_upd_q, w_upd_d;
    logic              err_q, err_d;

    logic [WBits-1:0]  canon_w;
    logic              xfer;

    for (genvar k = 0; k < NCodes; k++) begin : g_canon
        ternary_code_canon u_canon (
            .code_i (shadow_q[2*k +: 2]),
            .code_o (canon_w[2*k +: 2])
        );
    end

    assign byte_ready = (state_q == LD_DATA) || (state_q == LD_CKSUM);
    assign xfer       = byte_valid && byte_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cksum_d   = cksum_q;
        shadow_d  = shadow_q;
        w_d       = w_q;
        w_valid_d = w_valid_q;
        w_upd_d   = 1'b0;
        err_d     = err_q;

        // A restart wins over any transfer or pending commit in the same cycle.
        if (load_start) begin
            state_d = LD_DATA;
            count_d = '0;
            cksum_d = CKSUM_SEED;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                LD_DATA: begin
                    if (xfer) begin
                        shadow_d[8*count_q +: 8] = byte_in;
                        cksum_d                  = cksum_q ^ byte_in;
                        if (count_q == CntW'(NBytes - 1)) begin
                            state_d = LD_CKSUM;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                LD_CKSUM: begin
                    if (xfer) begin
                        if (byte_in == cksum_q) begin
                            state_d = LD_COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = LD_IDLE;
                        end
                    end
                end
                LD_COMMIT: begin
                    if (!commit_hold) begin
                        w_d       = canon_w;
                        w_valid_d = 1'b1;
                        w_upd_d   = 1'b1;
                        state_d   = LD_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LD_IDLE;
            count_q   <= '0;
            cksum_q   <= CKSUM_SEED;
            shadow_q  <= '0;
            w_q       <= '0;
            w_valid_q <= 1'b0;
            w_upd_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cksum_q   <= cksum_d;
            shadow_q  <= shadow_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            w_upd_q   <= w_upd_d;
            err_q     <= err_d;
        end
    end

    assign W         = w_q;
    assign w_valid   = w_valid_q;
    assign w_updated = w_upd_q;
    assign load_busy = (state_q != LD_IDLE);
    assign load_err  = err_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Scoreboard bench for ternary_weight_loader: expected W values are queued when a
// frame is issued and popped by a monitor on every w_updated pulse.
module tb_ternary_weight_loader;

    localparam int unsigned NB = 32;
    localparam logic [255:0] W_ZERO = '0;
    localparam logic [255:0] W_POS  = {128{2'b01}};
    localparam logic [255:0] W_NEG  = {128{2'b11}};
    localparam logic [255:0] W_13   = {32{8'h13}};
    localparam logic [255:0] W_DC   = {32{8'hDC}};

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         commit_hold;
    logic [255:0] W;
    logic         w_valid;
    logic         w_updated;
    logic         load_busy;
    logic         load_err;

    int checks   = 0;
    int failures = 0;
    logic [255:0] expq[$];

    ternary_weight_loader #(.InLen(16), .OutLen(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .commit_hold (commit_hold),
        .W           (W),
        .w_valid     (w_valid),
        .w_updated   (w_updated),
        .load_busy   (load_busy),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && w_updated) begin
                if (expq.size() == 0) begin
                    chk1("unexpected_w_updated", w_updated, 1'b0);
                end else begin
                    chk("commit_W", W, expq.pop_front());
                    chk1("commit_w_valid", w_valid, 1'b1);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        while (!byte_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) chk1("byte_ready_timeout", byte_ready, 1'b1);
        next_cycle();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic start_frame();
        load_start = 1'b1;
        next_cycle();
        load_start = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] d, input logic [7:0] ck, input bit gaps);
        for (int i = 0; i < NB; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) next_cycle();
            send_byte(d);
        end
        if (gaps) repeat ($urandom_range(0, 2)) next_cycle();
        send_byte(ck);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] ck, input bit gaps);
        start_frame();
        send_body(d, ck, gaps);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; commit_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h3C;
        repeat (3) next_cycle();
        @(negedge clk);
        chk ("reset_W",          W,          W_ZERO);
        chk1("reset_w_valid",    w_valid,    1'b0);
        chk1("idle_byte_ready",  byte_ready, 1'b0);
        chk1("idle_load_busy",   load_busy,  1'b0);
        chk1("reset_load_err",   load_err,   1'b0);
        next_cycle();
        byte_valid = 1'b0;

        // Good frame: W updates exactly one edge after the checksum transfer.
        expq.push_back(W_POS);
        send_frame(8'h55, 8'hA5, 1'b0);
        @(negedge clk);
        chk1("pre_commit_w_updated", w_updated, 1'b0);
        chk1("pre_commit_w_valid",   w_valid,   1'b0);
        next_cycle();
        chk ("good_W",         W,         W_POS);
        chk1("good_w_updated", w_updated, 1'b1);
        next_cycle();
        chk1("good_pulse_len", w_updated, 1'b0);

        // Bad checksum leaves W alone and sets the sticky error.
        send_frame(8'hFF, 8'h00, 1'b0);
        @(negedge clk);
        chk1("bad_load_err",  load_err,  1'b1);
        chk1("bad_load_busy", load_busy, 1'b0);
        chk ("bad_W",         W,         W_POS);
        repeat (3) next_cycle();
        start_frame();
        @(negedge clk);
        chk1("restart_clears_err", load_err,  1'b0);
        chk1("restart_busy",       load_busy, 1'b1);
        next_cycle();

        // Canonicalisation with the commit held off for five cycles.
        commit_hold = 1'b1;
        expq.push_back(W_NEG);
        send_frame(8'hAA, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("hold_byte_ready", byte_ready, 1'b0);
            chk1("hold_busy",       load_busy,  1'b1);
            chk ("hold_W",          W,          W_POS);
        end
        commit_hold = 1'b0;
        next_cycle();
        chk ("release_W",         W,         W_NEG);
        chk1("release_w_updated", w_updated, 1'b1);

        // Abort after 10 bytes; the byte colliding with load_start must be dropped.
        next_cycle();
        start_frame();
        repeat (10) send_byte(8'hFF);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h00;
        next_cycle();
        load_start = 1'b0;
        byte_valid = 1'b0;
        expq.push_back(W_13);
        send_body(8'h12, 8'hA5, 1'b0);
        repeat (2) next_cycle();
        chk ("abort_W",        W,        W_13);
        chk1("abort_load_err", load_err, 1'b0);

        // Same frame gapless and with byte_valid gaps: both commit the same W.
        expq.push_back(W_DC);
        send_frame(8'h9C, 8'hA5, 1'b0);
        repeat (2) next_cycle();
        expq.push_back(W_DC);
        send_frame(8'h9C, 8'hA5, 1'b1);
        repeat (2) next_cycle();
        chk("gapped_W", W, W_DC);

        // Reset mid-frame clears the active matrix too.
        start_frame();
        repeat (5) send_byte(8'h55);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk ("midrst_W",          W,          W_ZERO);
        chk1("midrst_w_valid",    w_valid,    1'b0);
        chk1("midrst_load_busy",  load_busy,  1'b0);
        chk1("midrst_byte_ready", byte_ready, 1'b0);
        next_cycle();

        // load_start during a held commit cancels it.
        commit_hold = 1'b1;
        send_frame(8'h55, 8'hA5, 1'b0);
        next_cycle();
        start_frame();
        commit_hold = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk ("cancel_W",       W,       W_ZERO);
        chk1("cancel_w_valid", w_valid, 1'b0);

        repeat (2) next_cycle();
        chk("pending_commits", 256'(expq.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
